mux_rr_sched: RTL and testbench
===============================

Name: mux_rr_sched

Overview:
- Round-robin scheduler that shares one muxN tree output (Z) among N requesters.
- Drives the tree's SEL bus and holds it stable while the owner uses it.
- Waits a programmable settle time after every SEL change so the combinational tree depth has resolved before SEL_VLD asserts.
- Sits beside the tree; the mux tree itself stays purely structural.

Parameters:
- N, 64, number of requesters / mux inputs (2..512, not required to be a power of 2)
- SEL_W, clog2(N), width of SEL
- SETTLE_CYC, 2, cycles between a SEL update and SEL_VLD rising (0 allowed)
- MAX_HOLD, 16, maximum cycles in OWN before forced release (0 = unlimited)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset, synchronous, active-high
- REQ  input  N  per-requester request level
- DONE  input  1  owner finished; release the grant
- GNT  output  N  one-hot grant; all zeros when no owner
- SEL  output  SEL_W  mux tree select; carries the owner index
- SEL_VLD  output  1  high when the tree output Z is settled and valid for the owner
- BUSY  output  1  high in the SETTLE and OWN states
- TIMEOUT  output  1  one-cycle pulse when MAX_HOLD forces a release

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high.
- Reset values: state=IDLE, PTR=0, SEL=0, GNT=0, SEL_VLD=0, BUSY=0, TIMEOUT=0, all counters=0.
- Reset mid-operation: a grant in progress is dropped on the next edge with no TIMEOUT pulse.
- States: IDLE, SETTLE, OWN.
- IDLE:
  - If REQ!=0, pick the lowest index i>=PTR with REQ[i]=1; if none, wrap to the lowest index <PTR.
  - Register SEL=i, GNT=1<<i, load the settle counter with SETTLE_CYC.
  - Go to SETTLE, or straight to OWN when SETTLE_CYC=0.
- SETTLE:
  - Counter decrements each cycle; on reaching 0, go to OWN.
  - If REQ[owner] drops during SETTLE, release immediately (release rules below; no TIMEOUT).
- OWN:
  - SEL_VLD=1; the hold counter increments from 0 each cycle.
  - Release on the first of: DONE=1; REQ[owner]=0; hold counter = MAX_HOLD-1 with MAX_HOLD!=0.
  - When the MAX_HOLD condition is met at the same edge as DONE or a REQ drop, TIMEOUT does not pulse; DONE has priority.
- Release (registered, same edge):
  - GNT=0, SEL_VLD=0, PTR=(owner+1) wraps to 0 when owner=N-1, state goes to IDLE.
  - SEL keeps its last value; it is never changed outside IDLE->grant, so the tree sees no spurious toggles.
- Latency:
  - REQ seen in IDLE at edge t gives GNT/SEL at t+1 and SEL_VLD at t+1+SETTLE_CYC.
  - After a release there is a mandatory 1-cycle IDLE gap before the next grant.
- Fairness: a requester that keeps REQ high is served within N grants.
- SEL stability: SEL does not change while SEL_VLD=1.
- Index range: when N is not a power of 2, indices >=N are never produced on SEL.
- DONE outside OWN is ignored.
- REQ bits of non-owners may change at any time without effect until the next IDLE arbitration.

Decomposition:
- Package mux_sched_pkg holds:
  - the state enum (IDLE/SETTLE/OWN)
  - a clog2 function
  - the counter width constant derived from max(SETTLE_CYC, MAX_HOLD)
- Sub-module mux_rr_pick: combinational rotating priority encoder.
  - Inputs: REQ, PTR.
  - Outputs: index, any_valid.
- The FSM, counters and pointer stay in mux_rr_sched.

Test Plan (N=8, SETTLE_CYC=2, MAX_HOLD=4 unless noted):
- Single request: REQ=0x04 from reset -> GNT=0x04 and SEL=2 one cycle later; SEL_VLD two cycles after that; DONE -> GNT=0, PTR=3.
- Rotation: REQ held at 0x81, DONE pulsed in each OWN -> grant order 0,7,0,7; one IDLE cycle between grants; SEL never changes while SEL_VLD=1.
- Wrap-around: PTR=7 after granting 6, REQ=0x41 -> next grant to 0, then 6.
- Timeout: REQ=0x02 held, no DONE -> SEL_VLD high exactly 4 cycles; TIMEOUT pulses once on the release edge; with MAX_HOLD=0 the grant is held indefinitely.
- Simultaneous events: DONE on the same edge the hold limit hits -> release with TIMEOUT=0; REQ[owner] dropped in SETTLE -> release with SEL_VLD never asserted.
- Reset mid-grant: RST=1 during OWN -> next edge GNT=0, SEL=0, SEL_VLD=0, PTR=0; with SETTLE_CYC=0, REQ=0x10 -> SEL_VLD rises in the same cycle as GNT.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// ============================================================================
// Module  : mux_sched_pkg
// Brief   : Shared types and sizing helpers for the round-robin mux scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OWN    = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // One counter serves both the settle countdown and the hold count-up.
    function automatic int cnt_width(input int settle, input int hold);
        int m;
        int w;
        m = (settle > hold) ? settle : hold;
        w = clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_pick.sv
// ============================================================================
// Module  : mux_rr_pick
// Brief   : Combinational rotating priority encoder (lowest index >= ptr, else wrap).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N     = 64,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any_valid
);

    logic             w_hi_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic [SEL_W-1:0] w_lo_idx;

    // Scanning downward lets the lowest matching index win in each half.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (SEL_W'(i) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(i);
                end else begin
                    w_lo_idx   = SEL_W'(i);
                end
            end
        end
    end

    assign o_idx       = w_hi_found ? w_hi_idx : w_lo_idx;
    assign o_any_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/mux_rr_sched.sv
// ============================================================================
// Module  : mux_rr_sched
// Brief   : Round-robin owner scheduler driving a mux tree SEL with settle time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int N          = 64,
    parameter int SEL_W      = clog2(N),
    parameter int SETTLE_CYC = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             busy,
    output logic             timeout
);

    localparam int               CNT_W       = cnt_width(SETTLE_CYC, MAX_HOLD);
    localparam logic [CNT_W-1:0] c_settle    = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [SEL_W-1:0] c_last_idx  = SEL_W'(N - 1);
    localparam logic [N-1:0]     c_one       = N'(1);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_gnt;
    logic             r_vld;
    logic             r_busy;
    logic             r_timeout;

    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic             w_owner_req;
    logic             w_hold_hit;
    logic [SEL_W-1:0] w_next_ptr;

    mux_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_idx       (w_idx),
        .o_any_valid (w_any)
    );

    assign w_owner_req = req[r_sel];
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_cnt == c_hold_last);
    assign w_next_ptr  = (r_sel == c_last_idx) ? '0 : r_sel + 1'b1;

    // SEL is only written on the IDLE->grant edge so the tree never sees a stray toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel  <= w_idx;
                        r_gnt  <= c_one << w_idx;
                        r_busy <= 1'b1;
                        r_cnt  <= c_settle;
                        if (SETTLE_CYC == 0) begin
                            r_state <= ST_OWN;
                            r_vld   <= 1'b1;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!w_owner_req) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_OWN;
                        r_vld   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ST_OWN: begin
                    if (done || !w_owner_req || w_hold_hit) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_vld     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_ptr     <= w_next_ptr;
                        r_timeout <= !done && w_owner_req;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign sel_vld = r_vld;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
// ============================================================================
// Module  : tb_mux_rr_sched
// Brief   : Scoreboard bench for mux_rr_sched (N=8) plus no-hold-limit and zero-settle variants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_sched;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         done, done2, done3;
    logic [N-1:0] req, req2, req3;
    logic [N-1:0] gnt, gnt2, gnt3;
    logic [2:0]   sel, sel2, sel3;
    logic         sel_vld, vld2, vld3;
    logic         busy, busy2, busy3;
    logic         timeout, to2, to3;

    always #5 clk = ~clk;

    mux_rr_sched #(.N(N), .SETTLE_CYC(2), .MAX_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt), .sel(sel),
        .sel_vld(sel_vld), .busy(busy), .timeout(timeout));

    mux_rr_sched #(.N(N), .SETTLE_CYC(2), .MAX_HOLD(0)) u_nohold (
        .clk(clk), .rst(rst), .req(req2), .done(done2), .gnt(gnt2), .sel(sel2),
        .sel_vld(vld2), .busy(busy2), .timeout(to2));

    mux_rr_sched #(.N(N), .SETTLE_CYC(0), .MAX_HOLD(4)) u_nosettle (
        .clk(clk), .rst(rst), .req(req3), .done(done3), .gnt(gnt3), .sel(sel3),
        .sel_vld(vld3), .busy(busy3), .timeout(to3));

    typedef struct {
        int idx;
        int vld;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int vld, input bit to);
        exp_t e;
        e.idx = idx;
        e.vld = vld;
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic wait_vld();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel_vld !== 1'b1 && n < 30);
        check("wait_vld", sel_vld, 1);
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === '0 && n < 30);
        check("wait_gnt", (gnt != '0), 1);
    endtask

    task automatic wait_rel();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt !== '0 && n < 30);
        check("wait_rel", gnt, 0);
    endtask

    // Waits for SEL_VLD, stays j more cycles, then pulses DONE with req updated alongside.
    task automatic own_done(input int j, input logic [N-1:0] nreq);
        wait_vld();
        repeat (j) @(negedge clk);
        done = 1'b1;
        req  = nreq;
        @(negedge clk);
        done = 1'b0;
    endtask

    // Monitor: one record per grant, compared over the grant's lifetime.
    initial begin : monitor
        bit   in_g = 0;
        int   cyc, vcnt, first;
        bit   sel_bad, busy_bad, to_seen;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!in_g && !$isunknown(gnt) && gnt != '0) begin
                in_g = 1; cyc = 0; vcnt = 0; first = -1;
                sel_bad = 0; busy_bad = 0; to_seen = 0;
                if (sb.size() == 0) begin
                    e.idx = -1; e.vld = 0; e.to = 0;
                    check("unexpected_grant", gnt, 0);
                end else begin
                    e = sb.pop_front();
                    check("grant_onehot", gnt, 32'd1 << e.idx);
                    check("grant_sel", sel, e.idx);
                end
            end
            if (in_g && gnt != '0) begin
                if (sel_vld === 1'b1) begin
                    if (vcnt == 0) first = cyc;
                    vcnt++;
                end
                if (sel !== 3'(e.idx)) sel_bad = 1;
                if (busy !== 1'b1) busy_bad = 1;
                if (timeout !== 1'b0) to_seen = 1;
                cyc++;
            end else if (in_g) begin
                in_g = 0;
                check("vld_cycles", vcnt, e.vld);
                check("timeout_pulse", timeout, e.to);
                check("sel_stable", sel_bad, 0);
                check("busy_in_grant", busy_bad, 0);
                check("no_early_timeout", to_seen, 0);
                check("busy_cleared", busy, 0);
                if (e.vld > 0) check("settle_latency", first, 2);
            end
        end
    end

    initial begin : stim
        bit to_seen;
        rst = 1'b1; done = 1'b0; req = '0;
        req2 = '0; done2 = 1'b0; req3 = '0; done3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_vld", sel_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: grant 2, ptr becomes 3.
        push(2, 2, 0);
        req = 8'h04;
        own_done(1, 8'h00);
        check("sel_kept_after_release", sel, 2);
        check("gnt_after_release", gnt, 0);
        repeat (2) @(negedge clk);

        // Rotation with ptr=3: 7,0,7,0.
        push(7, 1, 0); push(0, 1, 0); push(7, 1, 0); push(0, 1, 0);
        req = 8'h81;
        own_done(0, 8'h81);
        own_done(0, 8'h81);
        own_done(0, 8'h81);
        own_done(0, 8'h00);
        repeat (2) @(negedge clk);

        // Wrap: ptr=1 -> 6, ptr=7 -> 0, then 6.
        push(6, 1, 0); push(0, 1, 0); push(6, 1, 0);
        req = 8'h40;
        own_done(0, 8'h41);
        own_done(0, 8'h41);
        own_done(0, 8'h00);
        repeat (2) @(negedge clk);

        // Hold limit: ptr=7 wraps to 1, forced release after 4 valid cycles.
        push(1, 4, 1);
        req = 8'h02;
        wait_gnt();
        wait_rel();
        req = 8'h00;
        repeat (2) @(negedge clk);

        // DONE coincides with hold limit: no TIMEOUT.
        push(1, 4, 0);
        req = 8'h02;
        own_done(3, 8'h00);
        repeat (2) @(negedge clk);

        // Owner drops REQ during SETTLE.
        push(3, 0, 0);
        req = 8'h08;
        wait_gnt();
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Reset in OWN, then ptr must be back at 0.
        push(5, 1, 0);
        req = 8'h20;
        wait_vld();
        rst = 1'b1;
        req = 8'h00;
        @(negedge clk);
        check("midrst_gnt", gnt, 0);
        check("midrst_sel", sel, 0);
        check("midrst_vld", sel_vld, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        push(0, 1, 0);
        req = 8'h41;
        own_done(0, 8'h00);
        repeat (2) @(negedge clk);

        // MAX_HOLD=0: grant held indefinitely.
        req2 = 8'h02;
        to_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (to2 !== 1'b0) to_seen = 1;
        end
        check("nohold_gnt", gnt2, 8'h02);
        check("nohold_vld", vld2, 1);
        check("nohold_timeout", to_seen, 0);

        // SETTLE_CYC=0: SEL_VLD with GNT.
        req3 = 8'h10;
        @(negedge clk);
        check("nosettle_gnt", gnt3, 8'h10);
        check("nosettle_sel", sel3, 4);
        check("nosettle_vld", vld3, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
